// File: rtl/tile_draw_engine.sv
// Draws one map tile on an 8080-style LCD: window setup (CASET/PASET), RAMWR, then TILE*TILE RGB565 pixels.
// Optional GRID_LINES_EN: the last column and last row of each tile are drawn grey.
module tile_draw_engine #(
  parameter int TILE  = 20,
  parameter int MAP_W = 16,
  parameter int MAP_H = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_update,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic [2:0] obj_code,
  output logic       busy,
  output logic       cmd_done,
  output logic [7:0] lcd_d,
  output logic       lcd_dcx,
  output logic       lcd_wrx,
  output logic       lcd_csx,
  output logic [2:0] dbg_state
);

  // Handshake: a request is taken when en_update=1 at a rising edge while the FSM is IDLE;
  // requests arriving while busy are dropped, and cmd_done pulses once per accepted request.

  typedef enum logic [2:0] {
    S_IDLE, S_CASET, S_PASET, S_RAMWR, S_PIXELS, S_DONE
  } state_t;

  localparam int              CW     = (TILE > 1) ? $clog2(TILE) : 1;
  localparam logic [CW-1:0]   LAST   = CW'(TILE - 1);
  localparam logic [15:0]     TILE16 = 16'(TILE);

  state_t        state_q, state_d;
  logic          phase_q, phase_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic [3:0]    x_q, x_d;
  logic [3:0]    y_q, y_d;
  logic [2:0]    code_q, code_d;

  logic          in_range;
  logic [15:0]   xs, xe, ys, ye, pix;

  function automatic logic [15:0] code_colour(input logic [2:0] c);
    case (c)
      3'd0:    return 16'h0000;
      3'd1:    return 16'h07E0;
      3'd2:    return 16'h03E0;
      3'd3:    return 16'hF800;
      3'd4:    return 16'hFFFF;
      default: return 16'hF81F;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= 1'b0;
      idx_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      col_q   <= col_d;
      row_q   <= row_d;
      x_q     <= x_d;
      y_q     <= y_d;
      code_q  <= code_d;
    end
  end

  assign in_range = (32'(x) < MAP_W) && (32'(y) < MAP_H);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    col_d   = col_q;
    row_d   = row_q;
    x_d     = x_q;
    y_d     = y_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (en_update) begin
          x_d     = x;
          y_d     = y;
          code_d  = obj_code;
          phase_d = 1'b0;
          idx_d   = '0;
          col_d   = '0;
          row_d   = '0;
          state_d = in_range ? S_CASET : S_DONE;
        end
      end
      S_CASET, S_PASET: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          if (idx_q == 3'd4) begin
            idx_d   = '0;
            state_d = (state_q == S_CASET) ? S_PASET : S_RAMWR;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_RAMWR: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          idx_d   = '0;
          state_d = S_PIXELS;
        end
      end
      S_PIXELS: begin
        phase_d = ~phase_q;
        // idx_q[0] selects the high (0) or low (1) byte of the current pixel.
        if (phase_q) begin
          if (!idx_q[0]) begin
            idx_d = 3'd1;
          end else begin
            idx_d = '0;
            if (col_q == LAST) begin
              col_d = '0;
              if (row_q == LAST) begin
                row_d   = '0;
                state_d = S_DONE;
              end else begin
                row_d = row_q + 1'b1;
              end
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    xs  = {12'd0, x_q} * TILE16;
    xe  = xs + TILE16 - 16'd1;
    ys  = {12'd0, y_q} * TILE16;
    ye  = ys + TILE16 - 16'd1;
    pix = code_colour(code_q);
`ifdef GRID_LINES_EN
    if (col_q == LAST || row_q == LAST) pix = 16'h4208;
`endif
  end

  always_comb begin
    busy      = (state_q == S_CASET) || (state_q == S_PASET) ||
                (state_q == S_RAMWR) || (state_q == S_PIXELS);
    cmd_done  = (state_q == S_DONE);
    lcd_csx   = ~busy;
    lcd_wrx   = ~busy | phase_q;
    lcd_dcx   = 1'b1;
    lcd_d     = 8'h00;
    dbg_state = state_q;
    case (state_q)
      S_CASET: begin
        case (idx_q)
          3'd0:    begin lcd_d = 8'h2A; lcd_dcx = 1'b0; end
          3'd1:    lcd_d = xs[15:8];
          3'd2:    lcd_d = xs[7:0];
          3'd3:    lcd_d = xe[15:8];
          default: lcd_d = xe[7:0];
        endcase
      end
      S_PASET: begin
        case (idx_q)
          3'd0:    begin lcd_d = 8'h2B; lcd_dcx = 1'b0; end
          3'd1:    lcd_d = ys[15:8];
          3'd2:    lcd_d = ys[7:0];
          3'd3:    lcd_d = ye[15:8];
          default: lcd_d = ye[7:0];
        endcase
      end
      S_RAMWR: begin
        lcd_d   = 8'h2C;
        lcd_dcx = 1'b0;
      end
      S_PIXELS: lcd_d = idx_q[0] ? pix[7:0] : pix[15:8];
      default: ;
    endcase
  end

endmodule
